// File: rtl/main_mem_arbiter_if.sv
// Bus bundle between the L1 cache requesters, the main-memory port and main_mem_arbiter.
// Signal names carry the arbiter's point of view (_i into the arbiter, _o out of it).
interface main_mem_arbiter_if #(
    parameter int unsigned CACHE_BLOCK_SIZE = 128,
    parameter int unsigned ADDR_WIDTH       = 32
);
    logic                        ic_req_vld_i;
    logic [ADDR_WIDTH-1:0]       ic_req_addr_i;
    logic                        ic_req_rdy_o;
    logic                        ic_resp_vld_o;
    logic [CACHE_BLOCK_SIZE-1:0] ic_resp_data_o;
    logic                        dc_req_vld_i;
    logic [ADDR_WIDTH-1:0]       dc_req_addr_i;
    logic                        dc_req_rdy_o;
    logic                        dc_resp_vld_o;
    logic [CACHE_BLOCK_SIZE-1:0] dc_resp_data_o;
    logic                        dc_wb_vld_i;
    logic [ADDR_WIDTH-1:0]       dc_wb_addr_i;
    logic [CACHE_BLOCK_SIZE-1:0] dc_wb_data_i;
    logic                        dc_wb_rdy_o;
    logic                        mem_req_vld_o;
    logic                        mem_req_rdy_i;
    logic                        mem_req_we_o;
    logic [ADDR_WIDTH-1:0]       mem_req_addr_o;
    logic [CACHE_BLOCK_SIZE-1:0] mem_req_data_o;
    logic                        mem_resp_vld_i;
    logic [CACHE_BLOCK_SIZE-1:0] mem_resp_data_i;

    modport slave (
        input  ic_req_vld_i, ic_req_addr_i, dc_req_vld_i, dc_req_addr_i,
               dc_wb_vld_i, dc_wb_addr_i, dc_wb_data_i,
               mem_req_rdy_i, mem_resp_vld_i, mem_resp_data_i,
        output ic_req_rdy_o, ic_resp_vld_o, ic_resp_data_o,
               dc_req_rdy_o, dc_resp_vld_o, dc_resp_data_o, dc_wb_rdy_o,
               mem_req_vld_o, mem_req_we_o, mem_req_addr_o, mem_req_data_o
    );

    modport master (
        output ic_req_vld_i, ic_req_addr_i, dc_req_vld_i, dc_req_addr_i,
               dc_wb_vld_i, dc_wb_addr_i, dc_wb_data_i,
               mem_req_rdy_i, mem_resp_vld_i, mem_resp_data_i,
        input  ic_req_rdy_o, ic_resp_vld_o, ic_resp_data_o,
               dc_req_rdy_o, dc_resp_vld_o, dc_resp_data_o, dc_wb_rdy_o,
               mem_req_vld_o, mem_req_we_o, mem_req_addr_o, mem_req_data_o
    );
endinterface

// File: rtl/main_mem_arbiter.sv
// Shares one main-memory port between I-cache refills, D-cache repair reads and D-cache
// writebacks; a one-entry writeback buffer always drains before any read is granted.
module main_mem_arbiter #(
    parameter int unsigned CACHE_BLOCK_SIZE = 128,
    parameter int unsigned ADDR_WIDTH       = 32
) (
    input logic             clk_i,
    input logic             rst_i,
    main_mem_arbiter_if.slave bus
);
    localparam int unsigned OFFS = $clog2(CACHE_BLOCK_SIZE / 8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH - OFFS){1'b1}}, {OFFS{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RESP} state_e;
    typedef enum logic [1:0] {OWN_IC, OWN_DC, OWN_WB} owner_e;

    state_e                      state_q;
    owner_e                      owner_q;
    logic                        rr_last_dc_q;
    logic                        wb_vld_q;
    logic [ADDR_WIDTH-1:0]       wb_addr_q;
    logic [CACHE_BLOCK_SIZE-1:0] wb_data_q;
    logic                        mem_we_q;
    logic [ADDR_WIDTH-1:0]       mem_addr_q;
    logic [CACHE_BLOCK_SIZE-1:0] mem_data_q;
    logic                        ic_resp_vld_q, dc_resp_vld_q;
    logic [CACHE_BLOCK_SIZE-1:0] ic_resp_data_q, dc_resp_data_q;

    logic                  ic_gnt, dc_gnt, contended;
    logic [ADDR_WIDTH-1:0] gnt_addr;

    // Reads only while idle, out of reset, and with no writeback buffered or being offered.
    always_comb begin
        ic_gnt    = 1'b0;
        dc_gnt    = 1'b0;
        contended = bus.ic_req_vld_i && bus.dc_req_vld_i;
        if (rst_i && state_q == S_IDLE && !wb_vld_q && !bus.dc_wb_vld_i) begin
            if (contended) begin
                ic_gnt = rr_last_dc_q;
                dc_gnt = !rr_last_dc_q;
            end else begin
                ic_gnt = bus.ic_req_vld_i;
                dc_gnt = bus.dc_req_vld_i;
            end
        end
        gnt_addr = ic_gnt ? bus.ic_req_addr_i : bus.dc_req_addr_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q        <= S_IDLE;
            owner_q        <= OWN_IC;
            rr_last_dc_q   <= 1'b1;
            wb_vld_q       <= 1'b0;
            wb_addr_q      <= '0;
            wb_data_q      <= '0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_data_q     <= '0;
            ic_resp_vld_q  <= 1'b0;
            dc_resp_vld_q  <= 1'b0;
            ic_resp_data_q <= '0;
            dc_resp_data_q <= '0;
        end else begin
            ic_resp_vld_q <= 1'b0;
            dc_resp_vld_q <= 1'b0;
            if (bus.dc_wb_vld_i && !wb_vld_q) begin
                wb_vld_q  <= 1'b1;
                wb_addr_q <= bus.dc_wb_addr_i & ALIGN_MASK;
                wb_data_q <= bus.dc_wb_data_i;
            end
            case (state_q)
                S_IDLE: begin
                    if (wb_vld_q) begin
                        owner_q    <= OWN_WB;
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= wb_addr_q;
                        mem_data_q <= wb_data_q;
                        state_q    <= S_ISSUE;
                    end else if (ic_gnt || dc_gnt) begin
                        owner_q    <= ic_gnt ? OWN_IC : OWN_DC;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= gnt_addr & ALIGN_MASK;
                        mem_data_q <= '0;
                        state_q    <= S_ISSUE;
                        if (contended) rr_last_dc_q <= dc_gnt;
                    end
                end
                S_ISSUE: begin
                    if (bus.mem_req_rdy_i) state_q <= S_WAIT_RESP;
                end
                S_WAIT_RESP: begin
                    if (bus.mem_resp_vld_i) begin
                        case (owner_q)
                            OWN_IC: begin
                                ic_resp_vld_q  <= 1'b1;
                                ic_resp_data_q <= bus.mem_resp_data_i;
                            end
                            OWN_DC: begin
                                dc_resp_vld_q  <= 1'b1;
                                dc_resp_data_q <= bus.mem_resp_data_i;
                            end
                            default: wb_vld_q <= 1'b0;
                        endcase
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.ic_req_rdy_o   = ic_gnt;
    assign bus.dc_req_rdy_o   = dc_gnt;
    assign bus.dc_wb_rdy_o    = rst_i && !wb_vld_q;
    assign bus.mem_req_vld_o  = (state_q == S_ISSUE);
    assign bus.mem_req_we_o   = mem_we_q;
    assign bus.mem_req_addr_o = mem_addr_q;
    assign bus.mem_req_data_o = mem_data_q;
    assign bus.ic_resp_vld_o  = ic_resp_vld_q;
    assign bus.ic_resp_data_o = ic_resp_data_q;
    assign bus.dc_resp_vld_o  = dc_resp_vld_q;
    assign bus.dc_resp_data_o = dc_resp_data_q;
endmodule
